// File: rtl/aoc3_bank_sequencer.sv
// Streams one bank line into long_stack with a nums_left countdown, then drains the
// stack into a MAX_CAP-digit value and a running total. Optional check: `AOC3_LEN_CHECK_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module aoc3_bank_sequencer #(
  parameter int LINE_LEN = 100,
  parameter int MAX_CAP  = 12,
  parameter int ACC_W    = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               digit_in,
  input  logic                     digit_valid,
  input  logic                     digit_last,
  output logic                     digit_ready,
  output logic [`DATA_WIDTH-1:0]   stk_data_in,
  output logic                     stk_data_in_valid,
  output logic [`DATA_WIDTH-1:0]   stk_nums_left,
  output logic                     stk_clear,
  input  logic [$clog2(MAX_CAP):0] stk_size,
  input  logic                     stk_empty,
  input  logic                     stk_full,
  output logic                     stk_pop,
  input  logic [`DATA_WIDTH-1:0]   stk_top,
  output logic [ACC_W-1:0]         line_value,
  output logic                     line_valid,
  output logic [ACC_W-1:0]         total,
  output logic                     len_err
);

  localparam int DW     = `DATA_WIDTH;
  localparam int SIZE_W = $clog2(MAX_CAP) + 1;
  localparam logic [DW-1:0] LINE_LEN_C = DW'(LINE_LEN);

  localparam logic [2:0] FEED   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] REPORT = 3'd3;
  localparam logic [2:0] CLEAR  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    data_q, data_d;
  logic [DW-1:0]    nums_q, nums_d;
  logic             push_q, push_d;
  logic             clr_q, clr_d;
  logic             post_rst_q;
  logic [ACC_W-1:0] pow_q, pow_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_step;
  logic [ACC_W-1:0] line_value_q, line_value_d;
  logic [ACC_W-1:0] total_q, total_d;
  logic             line_valid_q, line_valid_d;
  logic             accept, last_pop;
  logic             unused_full;

  assign unused_full = stk_full;

  assign digit_ready       = (state_q == FEED) & ~reset;
  assign accept            = digit_ready & digit_valid;
  assign stk_pop           = (state_q == DRAIN) & ~stk_empty & ~reset;
  // The post-reset clear is gated so every output reads 0 while reset is held.
  assign stk_clear         = clr_q | (post_rst_q & ~reset);
  assign stk_data_in       = data_q;
  assign stk_data_in_valid = push_q;
  assign stk_nums_left     = nums_q;
  assign line_value        = line_value_q;
  assign line_valid        = line_valid_q;
  assign total             = total_q;

  // Top of stack is the least-significant digit, so weights grow as we pop.
  assign acc_step = acc_q + ACC_W'(stk_top) * pow_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    nums_d       = nums_q;
    push_d       = 1'b0;
    clr_d        = 1'b0;
    pow_d        = pow_q;
    acc_d        = acc_q;
    line_value_d = line_value_q;
    line_valid_d = 1'b0;
    total_d      = total_q;
    last_pop     = 1'b0;
    case (state_q)
      FEED: begin
        if (accept) begin
          push_d = 1'b1;
          data_d = DW'(digit_in);
          nums_d = cnt_q;
          cnt_d  = (cnt_q > DW'(1)) ? cnt_q - DW'(1) : DW'(1);
          if (digit_last) state_d = SETTLE;
        end
      end
      SETTLE: begin
        state_d = DRAIN;
        acc_d   = '0;
        pow_d   = ACC_W'(1);
      end
      DRAIN: begin
        if (!stk_empty) begin
          acc_d    = acc_step;
          pow_d    = (pow_q << 3) + (pow_q << 1);
          last_pop = (stk_size == SIZE_W'(1));
        end
        // Leaving on the final pop makes line_valid land the cycle the stack reads empty.
        if (stk_empty || last_pop) begin
          state_d      = REPORT;
          line_value_d = acc_d;
          line_valid_d = 1'b1;
          total_d      = total_q + acc_d;
        end
      end
      REPORT: begin
        state_d = CLEAR;
        clr_d   = 1'b1;
        cnt_d   = LINE_LEN_C;
        nums_d  = LINE_LEN_C;
      end
      CLEAR:   state_d = FEED;
      default: state_d = FEED;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (reset) begin
      state_q      <= FEED;
      cnt_q        <= LINE_LEN_C;
      data_q       <= '0;
      nums_q       <= LINE_LEN_C;
      push_q       <= 1'b0;
      clr_q        <= 1'b0;
      post_rst_q   <= 1'b1;
      pow_q        <= ACC_W'(1);
      acc_q        <= '0;
      line_value_q <= '0;
      line_valid_q <= 1'b0;
      total_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      nums_q       <= nums_d;
      push_q       <= push_d;
      clr_q        <= clr_d;
      post_rst_q   <= 1'b0;
      pow_q        <= pow_d;
      acc_q        <= acc_d;
      line_value_q <= line_value_d;
      line_valid_q <= line_valid_d;
      total_q      <= total_d;
    end
  end

`ifdef AOC3_LEN_CHECK_EN
  logic len_err_q;
  logic drain_first_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      len_err_q     <= 1'b0;
      drain_first_q <= 1'b0;
    end else begin
      drain_first_q <= (state_q == SETTLE);
      if ((accept && digit_last && cnt_q != DW'(1)) ||
          (drain_first_q && stk_size != SIZE_W'(MAX_CAP)))
        len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_aoc3_bank_sequencer.sv
// Bench for aoc3_bank_sequencer: behavioural long_stack plus a greedy max-subsequence
// reference model; directed, toggled and random lines, mid-drain reset, length check.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_aoc3_bank_sequencer;

  localparam int LINE_LEN = 15;
  localparam int MAX_CAP  = 12;
  localparam int ACC_W    = 64;
  localparam int DW       = `DATA_WIDTH;
  localparam int SIZE_W   = $clog2(MAX_CAP) + 1;

  logic              clock;
  logic              reset;
  logic [3:0]        digit_in;
  logic              digit_valid;
  logic              digit_last;
  logic              digit_ready;
  logic [DW-1:0]     stk_data_in;
  logic              stk_data_in_valid;
  logic [DW-1:0]     stk_nums_left;
  logic              stk_clear;
  logic [SIZE_W-1:0] stk_size;
  logic              stk_empty;
  logic              stk_full;
  logic              stk_pop;
  logic [DW-1:0]     stk_top;
  logic [ACC_W-1:0]  line_value;
  logic              line_valid;
  logic [ACC_W-1:0]  total;
  logic              len_err;

  aoc3_bank_sequencer #(.LINE_LEN(LINE_LEN), .MAX_CAP(MAX_CAP), .ACC_W(ACC_W)) dut (
    .clock(clock), .reset(reset),
    .digit_in(digit_in), .digit_valid(digit_valid), .digit_last(digit_last),
    .digit_ready(digit_ready),
    .stk_data_in(stk_data_in), .stk_data_in_valid(stk_data_in_valid),
    .stk_nums_left(stk_nums_left), .stk_clear(stk_clear),
    .stk_size(stk_size), .stk_empty(stk_empty), .stk_full(stk_full),
    .stk_pop(stk_pop), .stk_top(stk_top),
    .line_value(line_value), .line_valid(line_valid), .total(total), .len_err(len_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural long_stack: monotonic stack bounded by MAX_CAP and nums_left.
  logic [DW-1:0] stk_mem [MAX_CAP];
  int stk_cnt = 0;

  always_comb begin
    stk_top   = (stk_cnt > 0) ? stk_mem[stk_cnt-1] : '0;
    stk_size  = SIZE_W'(stk_cnt);
    stk_empty = (stk_cnt == 0);
    stk_full  = (stk_cnt == MAX_CAP);
  end

  always @(posedge clock) begin : stack_model
    int sz;
    int r;
    logic [DW-1:0] d;
    logic [DW-1:0] tmp [MAX_CAP];
    for (int i = 0; i < MAX_CAP; i++) tmp[i] = stk_mem[i];
    sz = stk_cnt;
    if (stk_clear === 1'b1) sz = 0;
    else if (stk_pop === 1'b1) begin
      if (sz > 0) sz--;
    end else if (stk_data_in_valid === 1'b1) begin
      d = stk_data_in;
      r = int'(stk_nums_left);
      while (sz > 0 && tmp[sz-1] < d && sz - 1 + r >= MAX_CAP) sz--;
      if (sz < MAX_CAP) begin
        tmp[sz] = d;
        sz++;
      end
    end
    for (int i = 0; i < MAX_CAP; i++) stk_mem[i] <= tmp[i];
    stk_cnt <= sz;
  end

  // Reference: the largest MAX_CAP-digit subsequence, chosen greedily by window maximum.
  int line_buf[$];

  function automatic logic [63:0] best_value();
    int n = line_buf.size();
    int pos = 0;
    logic [63:0] v = '0;
    for (int k = 0; k < MAX_CAP; k++) begin
      int bi = pos;
      for (int i = pos; i <= n - (MAX_CAP - k); i++)
        if (line_buf[i] > line_buf[bi]) bi = i;
      v = v * 10 + 64'(line_buf[bi]);
      pos = bi + 1;
    end
    return v;
  endfunction

  int          cyc = 0;
  always @(posedge clock) cyc++;

  logic [63:0] exp_q[$];
  logic [63:0] obs_vals[$];
  int          first_nums[$];
  logic [63:0] model_total = '0;
  logic [3:0]  pend_digit;
  int          pend_r, cmp_r;
  bit          pend_push = 0, busy = 0, after_rst = 0, prev_lvalid = 0, exp_err = 0;
  int          idx = 0, pops = 0, last_acc_cyc = 0, rep_total = 0;
  int          first_pops = -1, first_lat = -1;

  always @(negedge clock) begin : compare
    if (reset) begin
      after_rst = 1; prev_lvalid = 0; pend_push = 0; busy = 0; idx = 0; pops = 0;
      exp_err = 0; model_total = '0;
      line_buf.delete();
      exp_q.delete();
    end else begin
      check("stk_clear", stk_clear, after_rst || prev_lvalid);
      after_rst = 0;
      check("digit_ready", digit_ready, !busy);
      check("push_valid", stk_data_in_valid, pend_push);
      if (pend_push && stk_data_in_valid) begin
        check("push_data", stk_data_in, pend_digit);
        check("push_nums_left", stk_nums_left, pend_r);
      end
      if (rep_total == 0 && stk_data_in_valid && first_nums.size() < LINE_LEN)
        first_nums.push_back(int'(stk_nums_left));
      check("len_err", len_err, exp_err);
      if (stk_pop) pops++;
      if (line_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_line_valid: actual line_value %0d, expected no report", line_value);
        end else begin
          logic [63:0] ev;
          ev = exp_q.pop_front();
          check("line_value", line_value, ev);
          model_total = model_total + ev;
        end
        check("total", total, model_total);
        check("report_latency", cyc - last_acc_cyc, 2 + pops);
        if (rep_total == 0) begin
          first_pops = pops;
          first_lat  = cyc - last_acc_cyc;
        end
        obs_vals.push_back(line_value);
        rep_total++;
        pops = 0;
      end
      if (stk_clear) busy = 0;
      prev_lvalid = line_valid;
      pend_push = 0;
      if (digit_valid && digit_ready) begin
        cmp_r = (LINE_LEN - idx > 1) ? LINE_LEN - idx : 1;
        pend_push  = 1;
        pend_digit = digit_in;
        pend_r     = cmp_r;
        idx++;
        line_buf.push_back(int'(digit_in));
        if (digit_last) begin
          exp_q.push_back(best_value());
`ifdef AOC3_LEN_CHECK_EN
          if (cmp_r != 1) exp_err = 1;
`endif
          busy = 1;
          last_acc_cyc = cyc;
          idx = 0;
          line_buf.delete();
        end
      end
    end
  end

  // Stimulus helpers: mode 0 continuous, 1 valid every other cycle, 2 random gaps.
  int tx_line[$];

  task automatic load_str(input string s);
    tx_line.delete();
    for (int i = 0; i < s.len(); i++) tx_line.push_back(int'(s[i]) - 48);
  endtask

  task automatic send_digit(input logic [3:0] d, input logic last, input int mode);
    bit got = 0;
    int budget = 0;
    if (mode == 1) begin
      digit_valid = 1'b0;
      @(posedge clock); #1;
    end else if (mode == 2) begin
      repeat ($urandom_range(0, 2)) begin
        digit_valid = 1'b0;
        @(posedge clock); #1;
      end
    end
    digit_in = d; digit_last = last; digit_valid = 1'b1;
    while (!got && budget < 100) begin
      @(negedge clock);
      if (digit_ready) got = 1;
      budget++;
    end
    @(posedge clock); #1;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: digit %0d not accepted within 100 cycles", d);
    end
  endtask

  task automatic send_line(input int mode);
    for (int i = 0; i < tx_line.size(); i++)
      send_digit(4'(tx_line[i]), i == tx_line.size() - 1, mode);
  endtask

  task automatic wait_reports(input int n);
    int budget = 0;
    while (obs_vals.size() < n && budget < 300) begin
      @(posedge clock);
      budget++;
    end
    if (obs_vals.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL report_timeout: actual %0d reports, expected %0d", obs_vals.size(), n);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_digit_ready"}, digit_ready, 0);
    check({tag, "_push_valid"}, stk_data_in_valid, 0);
    check({tag, "_push_data"}, stk_data_in, 0);
    check({tag, "_nums_left"}, stk_nums_left, LINE_LEN);
    check({tag, "_stk_clear"}, stk_clear, 0);
    check({tag, "_stk_pop"}, stk_pop, 0);
    check({tag, "_line_valid"}, line_valid, 0);
    check({tag, "_line_value"}, line_value, 0);
    check({tag, "_total"}, total, 0);
    check({tag, "_len_err"}, len_err, 0);
  endtask

  string       lines[4] = '{"987654321111111", "811111111111119",
                            "234234234234278", "818181911112111"};
  logic [63:0] vals[4]  = '{64'd987654321111, 64'd811111111119,
                            64'd434234234278, 64'd888911112111};

  initial begin : main
    int budget;
    bit seen;
    reset = 1'b1; digit_in = '0; digit_valid = 1'b0; digit_last = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_clear", stk_clear, 1);
    @(posedge clock); #1;

    // Four lines back to back; the next line's first digit waits through each drain.
    obs_vals.delete();
    for (int l = 0; l < 4; l++) begin
      load_str(lines[l]);
      send_line(0);
    end
    digit_valid = 1'b0;
    wait_reports(4);
    for (int l = 0; l < 4; l++)
      if (l < obs_vals.size()) check("directed_value", obs_vals[l], vals[l]);
    @(negedge clock);
    check("directed_total", total, 64'd3121910778619);
    check("first_line_pops", first_pops, 12);
    check("first_line_latency", first_lat, 14);
    check("first_line_push_count", first_nums.size(), LINE_LEN);
    for (int i = 0; i < LINE_LEN; i++)
      if (i < first_nums.size()) check("first_line_nums_left", first_nums[i], LINE_LEN - i);

    // Same lines with digit_valid toggled every other cycle.
    obs_vals.delete();
    for (int l = 0; l < 4; l++) begin
      load_str(lines[l]);
      send_line(1);
    end
    digit_valid = 1'b0;
    wait_reports(4);
    for (int l = 0; l < 4; l++)
      if (l < obs_vals.size()) check("toggled_value", obs_vals[l], vals[l]);

    // Random full-length lines with random valid gaps.
    obs_vals.delete();
    for (int l = 0; l < 6; l++) begin
      tx_line.delete();
      for (int i = 0; i < LINE_LEN; i++) tx_line.push_back(int'($urandom_range(0, 9)));
      send_line(2);
    end
    digit_valid = 1'b0;
    wait_reports(6);

    // Reset in the middle of draining line 2, then resend line 2.
    obs_vals.delete();
    load_str(lines[0]);
    send_line(0);
    load_str(lines[1]);
    send_line(0);
    digit_valid = 1'b0;
    budget = 0; seen = 0;
    while (!seen && budget < 60) begin
      @(negedge clock);
      if (stk_pop && obs_vals.size() == 1) seen = 1;
      budget++;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: line 2 drain not observed within 60 cycles");
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock);
    @(negedge clock);
    check_zero_outputs("mid_drain_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_drain_post_clear", stk_clear, 1);
    @(posedge clock); #1;
    load_str(lines[1]);
    send_line(0);
    digit_valid = 1'b0;
    wait_reports(2);
    @(negedge clock);
    check("resent_total", total, 64'd811111111119);

    // Short line: still reported; len_err follows the build option.
    obs_vals.delete();
    load_str("55555555555555");
    send_line(0);
    digit_valid = 1'b0;
    wait_reports(1);
    if (obs_vals.size() > 0) check("short_line_value", obs_vals[0], 64'd555555555555);
    @(negedge clock);
`ifdef AOC3_LEN_CHECK_EN
    check("short_line_len_err", len_err, 1);
`else
    check("short_line_len_err", len_err, 0);
`endif
    repeat (4) @(posedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded 20000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
